// File: rtl/dma_xfer_engine.sv
// Block-transfer sequencer for the shared address/data bus. Requests the bus,
// copies word_count words from src_addr to dst_addr one word at a time (a read
// strobe, a capture cycle, then a write strobe), then releases the bus and
// pulses done. All outputs are registered from the next state.
module dma_xfer_engine #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic              bus_req,
  input  logic              bus_grant,
  output logic [ADDR_W-1:0] address_out,
  output logic [DATA_W-1:0] data_out,
  output logic              data_out_en,
  input  logic [DATA_W-1:0] data_in,
  output logic              read_dma,
  output logic              write_dma,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StReq     = 3'd1;
  localparam logic [2:0] StRead    = 3'd2;
  localparam logic [2:0] StCapture = 3'd3;
  localparam logic [2:0] StWrite   = 3'd4;
  localparam logic [2:0] StRelease = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] hold_q, hold_d;

  logic              bus_req_d, read_d, write_d, busy_d, done_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] dout_d;

  // Next-state logic for the sequencer and its address/count/holding registers.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          if (word_count != '0) begin
            state_d = StReq;
            src_d   = src_addr;
            dst_d   = dst_addr;
            cnt_d   = word_count;
          end else begin
            // Empty transfer: complete without touching the bus.
            done_d = 1'b1;
          end
        end
      end
      StReq: begin
        if (bus_grant) state_d = StRead;
      end
      StRead: begin
        state_d = StCapture;
      end
      StCapture: begin
        // Word in flight always finishes, even if the grant has gone away.
        hold_d  = data_in;
        state_d = StWrite;
      end
      StWrite: begin
        src_d = src_q + ADDR_W'(1);
        dst_d = dst_q + ADDR_W'(1);
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = StRelease;
        end else if (bus_grant) begin
          state_d = StRead;
        end else begin
          state_d = StReq;
        end
      end
      StRelease: begin
        if (!bus_grant) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output decode from the next state so the registered outputs track the state register.
  always_comb begin
    bus_req_d = (state_d == StReq) || (state_d == StRead) ||
                (state_d == StCapture) || (state_d == StWrite);
    read_d    = (state_d == StRead);
    write_d   = (state_d == StWrite);
    busy_d    = (state_d != StIdle);
    addr_d    = '0;
    dout_d    = '0;
    if (read_d) begin
      addr_d = src_d;
    end else if (write_d) begin
      addr_d = dst_d;
      dout_d = hold_d;
    end
  end

  // State, datapath and output registers; reset drops the bus at once.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      src_q       <= '0;
      dst_q       <= '0;
      cnt_q       <= '0;
      hold_q      <= '0;
      bus_req     <= 1'b0;
      read_dma    <= 1'b0;
      write_dma   <= 1'b0;
      data_out_en <= 1'b0;
      address_out <= '0;
      data_out    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      bus_req     <= bus_req_d;
      read_dma    <= read_d;
      write_dma   <= write_d;
      data_out_en <= write_d;
      address_out <= addr_d;
      data_out    <= dout_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

endmodule
